// File: rtl/srrc_tx_filter.sv
// 17-tap folded symmetric SRRC pulse-shaping FIR, 1s17 in/out.
// Four enable-gated pipeline stages, writable half-coefficient RAM.
module srrc_tx_filter #(
  parameter int NUM_TAPS = 17,
  parameter int DATA_W   = 18,
  parameter int COEF_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sam_clk_en,
  input  logic [DATA_W-1:0] sig_in,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [DATA_W-1:0] sig_out,
  output logic              sig_out_valid
);

  localparam int HALF  = NUM_TAPS / 2;
  localparam int P_W   = DATA_W + 1;
  localparam int M_W   = P_W + COEF_W;
  localparam int ACC_W = M_W + 4;
  localparam int R_W   = ACC_W - COEF_W + 2;
  localparam int H_W   = R_W - DATA_W + 1;

  localparam logic [COEF_W-1:0] C_ONE =
    {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] O_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] O_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ACC_W:0] RND =
    {{(ACC_W-COEF_W+2){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic [3:0] FILL_MAX = 4'd12;

  logic signed [DATA_W-1:0] x [NUM_TAPS];
  logic signed [P_W-1:0]    p [HALF+1];
  logic signed [M_W-1:0]    m [HALF+1];
  logic signed [COEF_W-1:0] c [HALF+1];
  logic signed [ACC_W-1:0]  acc;
  logic [3:0]               fill;

  logic signed [P_W-1:0]   p_nxt [HALF+1];
  logic signed [M_W-1:0]   m_nxt [HALF+1];
  logic signed [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]          rsum;
  logic [R_W-1:0]          r;
  logic [H_W-1:0]          r_hi;
  logic [DATA_W-1:0]       out_nxt;
  logic                    unused_rnd;

  always_comb begin
    for (int k = 0; k < HALF; k++) begin
      p_nxt[k] = {x[k][DATA_W-1], x[k]}
               + {x[NUM_TAPS-1-k][DATA_W-1],
                  x[NUM_TAPS-1-k]};
    end
    p_nxt[HALF] = {x[HALF][DATA_W-1], x[HALF]};
    for (int k = 0; k <= HALF; k++) begin
      m_nxt[k] = M_W'(p[k]) * M_W'(c[k]);
    end
    acc_nxt = '0;
    for (int k = 0; k <= HALF; k++) begin
      acc_nxt = acc_nxt + ACC_W'(m[k]);
    end
  end

  // round half up, then clamp to the 1s17 range
  always_comb begin
    rsum = {acc[ACC_W-1], acc} + RND;
    r    = rsum[ACC_W:COEF_W-1];
    r_hi = r[R_W-1:DATA_W-1];
    if ((&r_hi) || !(|r_hi)) begin
      out_nxt = r[DATA_W-1:0];
    end else if (r[R_W-1]) begin
      out_nxt = O_MIN;
    end else begin
      out_nxt = O_MAX;
    end
  end

  assign unused_rnd = ^rsum[COEF_W-2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
      for (int k = 0; k <= HALF; k++) begin
        p[k] <= '0;
        m[k] <= '0;
      end
      acc     <= '0;
      sig_out <= '0;
    end else if (sam_clk_en) begin
      x[0] <= sig_in;
      for (int k = 1; k < NUM_TAPS; k++) begin
        x[k] <= x[k-1];
      end
      for (int k = 0; k <= HALF; k++) begin
        p[k] <= p_nxt[k];
        m[k] <= m_nxt[k];
      end
      acc     <= acc_nxt;
      sig_out <= out_nxt;
    end
  end

  // stage 2 reads c before this edge's write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= HALF; k++) begin
        c[k] <= (k == HALF) ? C_ONE : '0;
      end
    end else if (coef_wr) begin
      for (int k = 0; k <= HALF; k++) begin
        if (coef_addr == 4'(k)) c[k] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (sam_clk_en && fill != FILL_MAX) begin
      fill <= fill + 4'd1;
    end
  end

  assign sig_out_valid = (fill == FILL_MAX);

endmodule
